// File: rtl/stream_arb_pkg.sv
// Shared definitions for the stream arbiters: FSM encodings, counter width,
// and an index-width helper.
package stream_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int PKT_CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority pick: first set req bit searching upward from
// last_grant+1, wrapping at PORTS. Purely combinational.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter  int PORTS = 4,
  localparam int IW    = idx_w(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic             any,
  output logic [IW-1:0]    idx
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = PORTS; off >= 1; off--) begin
      cand = int'(last_grant) + off;
      if (cand >= PORTS) cand = cand - PORTS;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter feeding one registered valid/ready stage.
// Optional per-port packet counters on pkt_count when ARB_PKT_COUNT_EN is defined.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_IDLE   | no grant held; pick next requester after last_grant
// ST_LOCKED | grant held; beats flow from the granted port until last
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int PORTS      = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int USE_LAST   = 1,
  localparam int IW         = idx_w(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]            in_valid,
  input  logic [PORTS-1:0]            in_last,
  output logic [PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic [IW-1:0]               out_port,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
`ifdef ARB_PKT_COUNT_EN
  ,
  output logic [PORTS*PKT_CNT_W-1:0]  pkt_count
`endif
);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic                  pick_any;
  logic [IW-1:0]         pick_idx;

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [IW-1:0]         out_port_q, out_port_d;
  logic                  out_valid_q, out_valid_d;

  logic                  stage_free;
  logic                  grant_valid;
  logic                  grant_last;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  beat_acc;
  logic                  beat_last;

  rr_pick #(.PORTS(PORTS)) u_pick (
    .req        (in_valid),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  assign stage_free  = !out_valid_q || out_ready;
  assign grant_valid = in_valid[grant_q];
  assign grant_last  = (USE_LAST != 0) ? in_last[grant_q] : 1'b1;
  assign grant_data  = in_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign beat_acc    = (state_q == ST_LOCKED) && grant_valid && stage_free;
  assign beat_last   = beat_acc && grant_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (beat_last) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    busy     = (state_q == ST_LOCKED);
    if (state_q == ST_LOCKED) in_ready[grant_q] = stage_free;
  end

  // A new beat may load in the same cycle the old one drains.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_port_d  = out_port_q;
    if (beat_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_last_d  = grant_last;
      out_port_d  = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_port_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_port_q  <= out_port_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_port  = out_port_q;

`ifdef ARB_PKT_COUNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q [PORTS];
  logic [PKT_CNT_W-1:0] pkt_cnt_d [PORTS];

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (beat_last) pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PORTS; i++) pkt_cnt_q[i] <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  for (genvar g = 0; g < PORTS; g++) begin : g_cnt
    assign pkt_count[g*PKT_CNT_W +: PKT_CNT_W] = pkt_cnt_q[g];
  end
`endif

endmodule
